keypad_matrix_ctrl: RTL and testbench
=====================================

# keypad_matrix_ctrl

Parametrised matrix-keypad controller; successor to the fixed 4x4 scanner in the IO input drivers. Drives a one-hot column scan, synchronises and debounces every key individually, and emits press/release events through a valid/ready event FIFO. Optionally runs a decimal-entry accumulator (`*` start, `#` commit, `A` backspace) that the MMIO layer reads as a committed value.

## Interface
Parameters:
- `ROWS`, 4: matrix rows (2..8).
- `COLS`, 4: matrix columns (2..8).
- `SCAN_DIV`, 50000: clock cycles each column is driven (≥4).
- `DEBOUNCE_SCANS`, 3: consecutive agreeing samples needed to change key state (1..15).
- `FIFO_DEPTH`, 8: event FIFO entries (power of 2, ≥2).
- `VALUE_W`, 16: accumulator width.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `row_i` in ROWS: row sense, active-low (pulled up), asynchronous to `clk`.
- `col_o` out COLS: column drive, one-hot, active-high.
- `key_down` out ROWS*COLS: debounced state, bit `r*COLS+c`.
- `ev_valid` out 1, `ev_ready` in 1, `ev_data` out EV_W: event stream, EV_W = 1+clog2(ROWS)+clog2(COLS), `{press, row, col}`.
- `ev_ovf` out 1: sticky, an event was dropped. `ovf_clr` in 1: clears it.
- `entry_active`, `entry_value[VALUE_W]`, `commit_valid`, `commit_value[VALUE_W]` out: accumulator (see Configuration).

## Operation
- Reset: `col_o`=1 (column 0), dwell counter 0, all `key_down`=0, debounce counters 0, FIFO empty, `ev_valid`=0, `ev_ovf`=0, `entry_active`=0, `entry_value`=0, `commit_valid`=0, `commit_value`=0. Reset mid-scan or mid-entry discards everything, no events.
- Scan: `col_o` advances to the next column after SCAN_DIV cycles, wrapping COLS-1→0.
- Sampling: `row_i` passes through a 2-flop synchroniser. It is sampled once, on the last dwell cycle of each column. Sample bit for key (r,c) = !row_sync[r].
- Debounce, per key: a sample equal to `key_down` clears that key's counter. A differing sample increments it. At DEBOUNCE_SCANS the key becomes a candidate to flip.
- One flip per sample: only the lowest-row candidate in the sampled column flips. It writes event `{new_state,r,c}` and clears its counter. Other candidates keep a saturated counter and flip on later scans.
- FIFO: show-ahead. `ev_valid` = !empty. Pop on `ev_valid && ev_ready`. A push when full and not popping drops the event and sets `ev_ovf`. A simultaneous push and pop when full succeeds. `ovf_clr` wins over a same-cycle set.

## Timing
- Press-to-event worst case: 2 sync + (DEBOUNCE_SCANS·COLS·SCAN_DIV) + SCAN_DIV cycles.
- `key_down` and the FIFO write happen in the sample cycle. `ev_valid` rises the following cycle.
- Accumulator updates in the cycle after the flip. `commit_valid` is a 1-cycle pulse.

## Configuration
- `KEYPAD_ACCUM_EN` defined: the accumulator is built. It requires ROWS=COLS=4; otherwise an elaboration error. It acts on press flips only, using the 4x4 legend: digits, `*`, `#`, A-D.
  - `*`: `entry_value`←0, `entry_active`←1.
  - Digit while active: value←value·10+d, saturating at 2^VALUE_W−1.
  - `A` while active: value←value/10.
  - `#` while active: `commit_value`←value, `commit_valid` pulses, `entry_active`←0.
  - B/C/D, and any key while inactive except `*`: ignored.
  - Works independently of FIFO fullness.
- Not defined: accumulator logic is absent. The four accumulator outputs are tied to 0.

## Structure
- `keypad_pkg`: legend enum (K0..K9, KA..KD, KSTAR, KHASH), `legend_4x4` lookup by (row,col), event struct, `ev_width()` helper.
- Sub-module `keypad_event_fifo` (parametrised depth/width, show-ahead, full/empty, push/pop).

## Test plan
- Defaults, SCAN_DIV=4, DEBOUNCE_SCANS=3; hold (r1,c2) low → `key_down[6]`=1, one event `{1,1,2}`. Release → `{0,1,2}`. No other events.
- Toggle `row_i[0]` for 2 scans then release → no event, `key_down` unchanged (bounce rejected).
- Press (0,1) and (3,1) together → `{1,0,1}` first, `{1,3,1}` exactly one scan later.
- `ev_ready`=0, generate 9 events with FIFO_DEPTH=8 → 8 stored, `ev_ovf`=1. Pulse `ovf_clr` → 0. Drain yields the first 8 in order.
- With `KEYPAD_ACCUM_EN`: `*`,1,2,3,A,4,`#` → `commit_value`=124, one `commit_valid` pulse. VALUE_W=8: `*`,9,9,9 → `entry_value`=255.
- Assert `rst_n` low mid-entry with a non-empty FIFO → all outputs at reset values, `col_o`=1.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad controller: key legend, event
// record and event-width calculation.
package keypad_pkg;

    typedef enum logic [3:0] {
        K0, K1, K2, K3, K4, K5, K6, K7, K8, K9,
        KA, KB, KC, KD, KSTAR, KHASH
    } key_legend_t;

    // Row/col fields sized for the largest supported matrix (8x8).
    typedef struct packed {
        logic       press;
        logic [2:0] row;
        logic [2:0] col;
    } key_event_t;

    function automatic int unsigned ev_width(input int unsigned rows, input int unsigned cols);
        return 1 + $clog2(rows) + $clog2(cols);
    endfunction

    function automatic key_legend_t legend_4x4(input logic [1:0] row, input logic [1:0] col);
        key_legend_t k;
        case ({row, col})
            4'h0:    k = K1;
            4'h1:    k = K2;
            4'h2:    k = K3;
            4'h3:    k = KA;
            4'h4:    k = K4;
            4'h5:    k = K5;
            4'h6:    k = K6;
            4'h7:    k = KB;
            4'h8:    k = K7;
            4'h9:    k = K8;
            4'hA:    k = K9;
            4'hB:    k = KC;
            4'hC:    k = KSTAR;
            4'hD:    k = K0;
            4'hE:    k = KHASH;
            default: k = KD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Show-ahead event FIFO; a push while full is accepted only if a pop happens in
// the same cycle.
module keypad_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW:0]                 wr_q, rd_q;
    logic                        wr_en, rd_en;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= push_data;
                wr_q                <= wr_q + 1'b1;
            end
            if (rd_en) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_ctrl.sv
// Matrix keypad scanner with per-key debounce and an event FIFO.
// Define KEYPAD_ACCUM_EN to build the decimal-entry accumulator (4x4 only).
module keypad_matrix_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned  ROWS           = 4,
    parameter int unsigned  COLS           = 4,
    parameter int unsigned  SCAN_DIV       = 50000,
    parameter int unsigned  DEBOUNCE_SCANS = 3,
    parameter int unsigned  FIFO_DEPTH     = 8,
    parameter int unsigned  VALUE_W        = 16,
    localparam int unsigned EV_W           = ev_width(ROWS, COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS-1:0]      row_i,
    output logic [COLS-1:0]      col_o,
    output logic [ROWS*COLS-1:0] key_down,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [EV_W-1:0]      ev_data,
    output logic                 ev_ovf,
    input  logic                 ovf_clr,
    output logic                 entry_active,
    output logic [VALUE_W-1:0]   entry_value,
    output logic                 commit_valid,
    output logic [VALUE_W-1:0]   commit_value
);
    localparam int unsigned NKEYS = ROWS * COLS;
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned DW    = $clog2(SCAN_DIV);

    logic [DW-1:0]         dwell_q, dwell_d;
    logic [CW-1:0]         col_q, col_d;
    logic [ROWS-1:0]       row_meta_q, row_sync_q;
    logic [NKEYS-1:0]      key_down_q, key_down_d;
    logic [NKEYS-1:0][3:0] deb_q, deb_d;
    logic                  sample_tick, flip;
    key_event_t            flip_ev;
    logic                  fifo_full, fifo_empty, pop, drop;
    logic                  ev_ovf_q, ev_ovf_d;
    logic                  unused_ev_bits;

    always_comb begin
        sample_tick = (dwell_q == DW'(SCAN_DIV - 1));
        dwell_d     = sample_tick ? '0 : dwell_q + 1'b1;
        col_d       = col_q;
        if (sample_tick) begin
            col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
        end
    end

    // Only the lowest-row candidate flips; later candidates hold a saturated count.
    always_comb begin
        key_down_d = key_down_q;
        deb_d      = deb_q;
        flip       = 1'b0;
        flip_ev    = '0;
        if (sample_tick) begin
            for (int k = 0; k < NKEYS; k++) begin
                if (col_q == CW'(k % COLS)) begin
                    if ((!row_sync_q[k / COLS]) == key_down_q[k]) begin
                        deb_d[k] = '0;
                    end else if (deb_q[k] >= 4'(DEBOUNCE_SCANS - 1)) begin
                        if (!flip) begin
                            flip          = 1'b1;
                            key_down_d[k] = !key_down_q[k];
                            deb_d[k]      = '0;
                            flip_ev.press = !key_down_q[k];
                            flip_ev.row   = 3'(k / COLS);
                            flip_ev.col   = 3'(col_q);
                        end else begin
                            deb_d[k] = 4'(DEBOUNCE_SCANS);
                        end
                    end else begin
                        deb_d[k] = deb_q[k] + 4'd1;
                    end
                end
            end
        end
    end

    assign pop  = ev_valid && ev_ready;
    assign drop = flip && fifo_full && !pop;

    always_comb begin
        ev_ovf_d = ev_ovf_q;
        if (ovf_clr) begin
            ev_ovf_d = 1'b0;
        end else if (drop) begin
            ev_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q    <= '0;
            col_q      <= '0;
            row_meta_q <= '1;
            row_sync_q <= '1;
            key_down_q <= '0;
            deb_q      <= '0;
            ev_ovf_q   <= 1'b0;
        end else begin
            dwell_q    <= dwell_d;
            col_q      <= col_d;
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
            key_down_q <= key_down_d;
            deb_q      <= deb_d;
            ev_ovf_q   <= ev_ovf_d;
        end
    end

    keypad_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (flip),
        .push_data ({flip_ev.press, flip_ev.row[RW-1:0], flip_ev.col[CW-1:0]}),
        .pop       (pop),
        .pop_data  (ev_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        col_o        = '0;
        col_o[col_q] = 1'b1;
    end

    assign key_down       = key_down_q;
    assign ev_valid       = !fifo_empty;
    assign ev_ovf         = ev_ovf_q;
    assign unused_ev_bits = ^{flip_ev.row, flip_ev.col};

`ifdef KEYPAD_ACCUM_EN
    if (ROWS != 4 || COLS != 4) begin : g_geom_check
        $error("keypad_matrix_ctrl: accumulator needs a 4x4 matrix");
    end

    localparam int unsigned PW = VALUE_W + 4;

    logic               acc_pend_q;
    key_legend_t        acc_key_q;
    logic               active_q, active_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               commit_q, commit_d;
    logic [VALUE_W-1:0] commit_val_q, commit_val_d;
    logic [PW-1:0]      shifted;

    always_comb begin
        active_d     = active_q;
        value_d      = value_q;
        commit_d     = 1'b0;
        commit_val_d = commit_val_q;
        shifted      = {4'b0, value_q} * PW'(10) + PW'(acc_key_q);
        if (acc_pend_q) begin
            case (acc_key_q)
                KSTAR: begin
                    value_d  = '0;
                    active_d = 1'b1;
                end
                KHASH: begin
                    if (active_q) begin
                        commit_val_d = value_q;
                        commit_d     = 1'b1;
                        active_d     = 1'b0;
                    end
                end
                KA: begin
                    if (active_q) begin
                        value_d = value_q / VALUE_W'(10);
                    end
                end
                KB, KC, KD: ;
                default: begin
                    if (active_q) begin
                        value_d = (shifted > PW'({VALUE_W{1'b1}})) ? '1 : shifted[VALUE_W-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_pend_q   <= 1'b0;
            acc_key_q    <= K0;
            active_q     <= 1'b0;
            value_q      <= '0;
            commit_q     <= 1'b0;
            commit_val_q <= '0;
        end else begin
            acc_pend_q   <= flip && flip_ev.press;
            acc_key_q    <= legend_4x4(flip_ev.row[1:0], flip_ev.col[1:0]);
            active_q     <= active_d;
            value_q      <= value_d;
            commit_q     <= commit_d;
            commit_val_q <= commit_val_d;
        end
    end

    assign entry_active = active_q;
    assign entry_value  = value_q;
    assign commit_valid = commit_q;
    assign commit_value = commit_val_q;
`else
    assign entry_active = 1'b0;
    assign entry_value  = '0;
    assign commit_valid = 1'b0;
    assign commit_value = '0;
`endif

endmodule

// File: tb/tb_keypad_matrix_ctrl.sv
// Directed bench for keypad_matrix_ctrl: 4x4 matrix, SCAN_DIV=4, DEBOUNCE_SCANS=3.
module tb_keypad_matrix_ctrl;
    localparam int SCAN = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] held;
    logic [3:0]  row_force;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic [15:0] key_down;
    logic        ev_valid, ev_ready;
    logic [4:0]  ev_data;
    logic        ev_ovf, ovf_clr;
    logic        entry_active, commit_valid;
    logic [15:0] entry_value, commit_value;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_commit = 0;
    int unsigned cyc = 0;
    logic [4:0]  ev_log[$];
    int unsigned ev_time[$];
    logic [4:0]  exp_drain [8] = '{5'd16, 5'd0, 5'd27, 5'd11, 5'd28, 5'd12, 5'd21, 5'd5};
    int          toggles [9] = '{0, 0, 11, 11, 12, 12, 5, 5, 10};

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_i[r] = ~((|(held[r*4 +: 4] & col_o)) | row_force[r]);
        end
    end

    keypad_matrix_ctrl #(
        .ROWS           (4),
        .COLS           (4),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (8),
        .VALUE_W        (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .row_i        (row_i),
        .col_o        (col_o),
        .key_down     (key_down),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_data      (ev_data),
        .ev_ovf       (ev_ovf),
        .ovf_clr      (ovf_clr),
        .entry_active (entry_active),
        .entry_value  (entry_value),
        .commit_valid (commit_valid),
        .commit_value (commit_value)
    );

`ifdef KEYPAD_ACCUM_EN
    logic [3:0] col8;
    logic [15:0] key_down8;
    logic       ev_valid8, ev_ovf8, active8, commit8;
    logic [4:0] ev_data8;
    logic [7:0] value8, commit_value8;

    keypad_matrix_ctrl #(
        .ROWS           (4),
        .COLS           (4),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (8),
        .VALUE_W        (8)
    ) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .row_i        (row_i),
        .col_o        (col8),
        .key_down     (key_down8),
        .ev_valid     (ev_valid8),
        .ev_ready     (1'b1),
        .ev_data      (ev_data8),
        .ev_ovf       (ev_ovf8),
        .ovf_clr      (1'b0),
        .entry_active (active8),
        .entry_value  (value8),
        .commit_valid (commit8),
        .commit_value (commit_value8)
    );
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            ev_log.push_back(ev_data);
            ev_time.push_back(cyc);
        end
        if (commit_valid) n_commit++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ev_at(input int i);
        if (i < ev_log.size()) return 32'(ev_log[i]);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] tm_at(input int i);
        if (i < ev_time.size()) return 32'(ev_time[i]);
        return 32'hDEAD;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_col"}, 32'(col_o), 32'h1);
        check_eq({tag, "_keys"}, 32'(key_down), 32'h0);
        check_eq({tag, "_valid"}, 32'(ev_valid), 32'h0);
        check_eq({tag, "_ovf"}, 32'(ev_ovf), 32'h0);
        check_eq({tag, "_active"}, 32'(entry_active), 32'h0);
        check_eq({tag, "_value"}, 32'(entry_value), 32'h0);
        check_eq({tag, "_cvalid"}, 32'(commit_valid), 32'h0);
        check_eq({tag, "_cvalue"}, 32'(commit_value), 32'h0);
    endtask

`ifdef KEYPAD_ACCUM_EN
    task automatic tap(input int k);
        held[k] = 1'b1;
        cycles(5 * SCAN);
        held[k] = 1'b0;
        cycles(5 * SCAN);
    endtask
`endif

    initial begin
        rst_n     = 1'b1;
        held      = '0;
        row_force = '0;
        ev_ready  = 1'b1;
        ovf_clr   = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        cycles(4);
        check_eq("scan_col1", 32'(col_o), 32'h2);
        cycles(12);
        check_eq("scan_wrap", 32'(col_o), 32'h1);

        // Single key (1,2) press and release.
        held[6] = 1'b1;
        cycles(6 * SCAN);
        check_eq("press_keys", 32'(key_down), 32'h0040);
        check_eq("press_count", ev_log.size(), 1);
        check_eq("press_ev", ev_at(0), 32'd22);
        held[6] = 1'b0;
        cycles(6 * SCAN);
        check_eq("rel_keys", 32'(key_down), 32'h0);
        check_eq("rel_count", ev_log.size(), 2);
        check_eq("rel_ev", ev_at(1), 32'd6);

        // Row 0 low for only two scans: too short to pass debounce.
        row_force[0] = 1'b1;
        cycles(2 * SCAN);
        check_eq("bounce_keys_mid", 32'(key_down), 32'h0);
        row_force[0] = 1'b0;
        cycles(4 * SCAN);
        check_eq("bounce_keys", 32'(key_down), 32'h0);
        check_eq("bounce_count", ev_log.size(), 2);

        // Two keys in column 1: lower row first, the other one scan later.
        held[1]  = 1'b1;
        held[13] = 1'b1;
        cycles(6 * SCAN);
        check_eq("dual_keys", 32'(key_down), 32'h2002);
        check_eq("dual_count", ev_log.size(), 4);
        check_eq("dual_first", ev_at(2), 32'd17);
        check_eq("dual_second", ev_at(3), 32'd29);
        check_eq("dual_gap", tm_at(3) - tm_at(2), 32'd16);
        held[1]  = 1'b0;
        held[13] = 1'b0;
        cycles(6 * SCAN);
        check_eq("dual_rel_count", ev_log.size(), 6);
        check_eq("dual_rel_first", ev_at(4), 32'd1);
        check_eq("dual_rel_second", ev_at(5), 32'd13);

`ifdef KEYPAD_ACCUM_EN
        tap(12); tap(0); tap(1); tap(2); tap(3); tap(4); tap(14);
        check_eq("acc_commit_value", 32'(commit_value), 32'd124);
        check_eq("acc_commit_pulses", n_commit, 1);
        check_eq("acc_inactive", 32'(entry_active), 32'h0);
        tap(12); tap(10); tap(10); tap(10);
        check_eq("acc_value16", 32'(entry_value), 32'd999);
        check_eq("acc_value8_sat", 32'(value8), 32'd255);
        check_eq("acc_active", 32'(entry_active), 32'h1);
`endif

        // Overflow: nine events into an eight-deep FIFO with no reader.
        ev_ready = 1'b0;
        ev_log.delete();
        ev_time.delete();
        for (int i = 0; i < 9; i++) begin
            held[toggles[i]] = ~held[toggles[i]];
            cycles(6 * SCAN);
            if (i == 7) begin
                check_eq("ovf_before", 32'(ev_ovf), 32'h0);
                check_eq("ovf_valid", 32'(ev_valid), 32'h1);
            end
        end
        check_eq("ovf_set", 32'(ev_ovf), 32'h1);
        check_eq("ovf_keys", 32'(key_down), 32'h0400);
`ifdef KEYPAD_ACCUM_EN
        check_eq("acc_full_fifo", 32'(entry_value), 32'd59);
`else
        check_eq("noacc_active", 32'(entry_active), 32'h0);
        check_eq("noacc_value", 32'(entry_value), 32'h0);
        check_eq("noacc_commits", n_commit, 0);
`endif
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        check_eq("ovf_clr", 32'(ev_ovf), 32'h0);
        ev_ready = 1'b1;
        cycles(12);
        check_eq("drain_count", ev_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("drain_%0d", i), ev_at(i), 32'(exp_drain[i]));
        end

        // Reset with a pending event (and, if built, an entry in progress).
        ev_ready = 1'b0;
        held[10] = 1'b0;
        cycles(6 * SCAN);
        check_eq("pre_reset_valid", 32'(ev_valid), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        cycles(2);
        rst_n    = 1'b1;
        ev_ready = 1'b1;
        cycles(4 * SCAN);
        check_eq("post_reset_valid", 32'(ev_valid), 32'h0);
        check_eq("post_reset_count", ev_log.size(), 8);
        check_eq("post_reset_keys", 32'(key_down), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
